// File: rtl/psum_lane_packer.sv
// Packs serial WIDTH-bit partial products into LANES-wide vectors via a ping-pong bank pair.
// Optional PACKER_FLUSH_EN adds in_flush/out_lanes so a partial vector can be closed early.
module psum_lane_packer #(
  parameter int LANES = 8,
  parameter int WIDTH = 17
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*WIDTH-1:0]    out_data
`ifdef PACKER_FLUSH_EN
  ,
  input  logic                      in_flush,
  output logic [$clog2(LANES):0]    out_lanes
`endif
);

  localparam int IDX_W = $clog2(LANES);
  localparam int CNT_W = IDX_W + 1;

  logic [WIDTH-1:0] bank_q [2][LANES];
  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0] lane_cnt_q, lane_cnt_d;

  logic accept;
  logic drain;
  logic last_lane;
  logic flush_close;
  logic close_vec;

  // Both handshake outputs come from registers only; no out_ready -> in_ready path.
  assign in_ready  = !full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;
  assign last_lane = (lane_cnt_q == IDX_W'(LANES - 1));

`ifdef PACKER_FLUSH_EN
  assign flush_close = in_flush && (accept || (lane_cnt_q != '0)) && !(accept && last_lane);
`else
  assign flush_close = 1'b0;
`endif

  assign close_vec = (accept && last_lane) || flush_close;

  // Close and drain always hit different banks, so both updates can apply together.
  always_comb begin
    full_d     = full_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    lane_cnt_d = lane_cnt_q;
    if (accept) begin
      lane_cnt_d = lane_cnt_q + 1'b1;
    end
    if (close_vec) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = !wr_bank_q;
      lane_cnt_d        = '0;
    end
    if (drain) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      lane_cnt_q <= '0;
    end else begin
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      lane_cnt_q <= lane_cnt_d;
    end
  end

  // Lane 0 write clears the rest of the bank so short (flushed) vectors read zero above.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int l = 0; l < LANES; l++) begin
          bank_q[b][l] <= '0;
        end
      end
    end else if (accept) begin
      for (int l = 0; l < LANES; l++) begin
        if (lane_cnt_q == IDX_W'(l)) begin
          bank_q[wr_bank_q][l] <= in_data;
        end else if (lane_cnt_q == '0) begin
          bank_q[wr_bank_q][l] <= '0;
        end
      end
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_out_lane
    assign out_data[WIDTH*gi +: WIDTH] = bank_q[rd_bank_q][gi];
  end

`ifdef PACKER_FLUSH_EN
  logic [CNT_W-1:0] lanes_q [2];

  always_ff @(posedge clk) begin
    if (rst) begin
      lanes_q[0] <= '0;
      lanes_q[1] <= '0;
    end else if (close_vec) begin
      lanes_q[wr_bank_q] <= {1'b0, lane_cnt_q} + CNT_W'(accept);
    end
  end

  assign out_lanes = lanes_q[rd_bank_q];
`endif

endmodule

// File: tb/tb_psum_lane_packer.sv
// Randomized + directed bench for psum_lane_packer against a queue-based vector model.
// Build with +define+PACKER_FLUSH_EN to also exercise in_flush/out_lanes.
module tb_psum_lane_packer;

  localparam int LANES = 8;
  localparam int W     = 17;
  localparam int VW    = LANES * W;

`ifdef PACKER_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_data;
`ifdef PACKER_FLUSH_EN
  logic          in_flush;
  logic [3:0]    out_lanes;
`endif

  always #5 clk = ~clk;

  psum_lane_packer #(.LANES(LANES), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PACKER_FLUSH_EN
    ,
    .in_flush  (in_flush),
    .out_lanes (out_lanes)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: completed vectors awaiting drain, their lane counts, and the partial vector.
  logic [VW-1:0] m_vq[$];
  int            m_lq[$];
  logic [W-1:0]  m_part[$];
  int            n_acc = 0;
  int            n_out = 0;

  task automatic check_eq(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] pack_part();
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < m_part.size(); i++) v[i*W +: W] = m_part[i];
    return v;
  endfunction

  // One clock: check registered outputs against the model, apply inputs, advance the model.
  task automatic cycle(input bit v, input logic [W-1:0] d, input bit ordy, input bit fl);
    bit m_rdy, m_acc, m_drn;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
`ifdef PACKER_FLUSH_EN
    in_flush  = fl;
`endif
    m_rdy = (m_vq.size() < 2);
    check_eq("in_ready", in_ready, m_rdy);
    check_eq("out_valid", out_valid, m_vq.size() > 0);
    if (m_vq.size() > 0) begin
      check_eq("out_data", out_data, m_vq[0]);
`ifdef PACKER_FLUSH_EN
      check_eq("out_lanes", out_lanes, m_lq[0]);
`endif
    end
    m_acc = v && m_rdy;
    m_drn = (m_vq.size() > 0) && ordy;
    @(posedge clk);
    if (m_drn) begin
      void'(m_vq.pop_front());
      void'(m_lq.pop_front());
      n_out++;
    end
    if (m_acc) begin
      m_part.push_back(d);
      n_acc++;
    end
    if (m_part.size() == LANES || (FLUSH_EN && fl && m_part.size() > 0)) begin
      m_vq.push_back(pack_part());
      m_lq.push_back(m_part.size());
      m_part.delete();
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef PACKER_FLUSH_EN
    in_flush  = 1'b0;
`endif
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_vq.delete();
    m_lq.delete();
    m_part.delete();
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b1);
  endtask

  task automatic drain_all();
    int k;
    k = 0;
    while (m_vq.size() > 0 && k < 100) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      k++;
    end
    check_eq("drain_done", m_vq.size(), 0);
    cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    int base_out, base_acc, cyc;
    logic [W-1:0] nxt;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef PACKER_FLUSH_EN
    in_flush  = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_out_data", out_data, '0);
    check_eq("reset_out_valid", out_valid, 1'b0);
    check_eq("reset_in_ready", in_ready, 1'b1);
`ifdef PACKER_FLUSH_EN
    check_eq("reset_out_lanes", out_lanes, 4'd0);
`endif
    rst = 1'b0;

    // Single vector 1..8 at full rate.
    base_out = n_out;
    for (int i = 1; i <= 8; i++) cycle(1'b1, W'(i), 1'b1, 1'b0);
    drain_all();
    check_eq("one_vector", n_out - base_out, 1);

    // Backpressure: exactly 16 samples fit before in_ready drops.
    base_out = n_out;
    base_acc = n_acc;
    nxt = 17'd1;
    for (int i = 0; i < 24; i++) begin
      base_acc = base_acc;
      cycle(1'b1, nxt, 1'b0, 1'b0);
      if (n_acc - base_acc > int'(nxt) - 1) nxt = nxt + 1'b1;
    end
    check_eq("stall_accepts", n_acc - base_acc, 16);
    cyc = 0;
    while (nxt <= 17'd20 && cyc < 200) begin
      cycle(1'b1, nxt, 1'b1, 1'b0);
      if (n_acc - base_acc > int'(nxt) - 1) nxt = nxt + 1'b1;
      cyc++;
    end
    check_eq("stall_all_accepted", n_acc - base_acc, 20);
    for (int i = 0; i < 4; i++) cycle(1'b1, W'(21 + i), 1'b1, 1'b0);
    drain_all();
    check_eq("stall_vectors", n_out - base_out, 3);

    // Full-rate all-ones stream.
    base_out = n_out;
    base_acc = n_acc;
    for (int i = 0; i < 64; i++) cycle(1'b1, 17'h1FFFF, 1'b1, 1'b0);
    drain_all();
    check_eq("stream_accepts", n_acc - base_acc, 64);
    check_eq("stream_vectors", n_out - base_out, 8);

    // Random valid/ready (and occasional flush when enabled).
    base_acc = n_acc;
    cyc = 0;
    while (n_acc - base_acc < 1000 && cyc < 20000) begin
      cycle(($urandom % 4) != 0, W'($urandom), ($urandom % 3) != 0, ($urandom % 16) == 0);
      cyc++;
    end
    check_eq("random_done", n_acc - base_acc >= 1000, 1'b1);
    drain_all();

    // Reset mid-vector discards the partial data.
    for (int i = 0; i < 5; i++) cycle(1'b1, W'(i + 100), 1'b0, 1'b0);
    do_reset();
    base_out = n_out;
    for (int i = 0; i < 8; i++) cycle(1'b1, W'(16 + i), 1'b1, 1'b0);
    drain_all();
    check_eq("post_reset_vectors", n_out - base_out, 1);

`ifdef PACKER_FLUSH_EN
    // Flush with the third sample, then a flush with nothing pending.
    base_out = n_out;
    cycle(1'b1, 17'hA, 1'b0, 1'b0);
    cycle(1'b1, 17'hB, 1'b0, 1'b0);
    cycle(1'b1, 17'hC, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    check_eq("flush_pending", m_vq.size(), 1);
    drain_all();
    check_eq("flush_vectors", n_out - base_out, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
